// File: rtl/nco_config_ctrl_if.sv
// Byte-level handshake from the I2C slave into the NCO configuration controller.
// The I2C slave drives it as master; the configuration controller listens as slave.
interface nco_config_ctrl_if;
  logic       frame_start;
  logic       frame_stop;
  logic       byte_valid;
  logic [7:0] byte_data;

  modport master (
    output frame_start,
    output frame_stop,
    output byte_valid,
    output byte_data
  );

  modport slave (
    input frame_start,
    input frame_stop,
    input byte_valid,
    input byte_data
  );
endinterface

// File: rtl/nco_config_ctrl.sv
// Decodes I2C frames (control byte + optional frequency/duty payload) into shadow
// registers and commits them atomically to the NCO on STOP, optionally on a phase wrap.
module nco_config_ctrl #(
  parameter int                FREQ_W       = 64,
  parameter int                DUTY_W       = 16,
  parameter logic [DUTY_W-1:0] RESET_DUTY   = DUTY_W'(16'h8000),
  parameter int                WRAP_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  nco_config_ctrl_if.slave      i2c,
  input  logic                  phase_wrap,
  output logic                  enable,
  output logic [1:0]            wave,
  output logic [FREQ_W-1:0]     frequency,
  output logic [DUTY_W-1:0]     duty_cycle,
  output logic                  cfg_update,
  output logic                  busy,
  output logic                  frame_err,
  output logic [7:0]            err_count
);

  localparam int FREQ_BYTES = FREQ_W / 8;
  localparam int DUTY_BYTES = DUTY_W / 8;
  localparam int MAX_BYTES  = (FREQ_BYTES > DUTY_BYTES) ? FREQ_BYTES : DUTY_BYTES;
  localparam int CNT_W      = $clog2(MAX_BYTES + 1);
  localparam int WAIT_W     = (WRAP_TIMEOUT > 2) ? $clog2(WRAP_TIMEOUT) : 1;

  // Control shadow bit positions (reserved bits 7:6 are never stored)
  localparam int C_EN   = 0;
  localparam int C_LF   = 3;
  localparam int C_LD   = 4;
  localparam int C_SYNC = 5;

  typedef enum logic [2:0] {
    IDLE, CTRL, FREQ, DUTY, WAIT_STOP, PEND, ABORT
  } state_t;

  state_t             state_reg, state_next, after_byte;
  logic [5:0]         ctrl_reg, ctrl_next;
  logic [FREQ_W-1:0]  freq_reg, freq_next, freq_shift;
  logic [DUTY_W-1:0]  duty_reg, duty_next, duty_shift;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WAIT_W-1:0]  wait_reg, wait_next;
  logic               commit, discard;

  generate
    if (FREQ_W > 8) begin : g_freq_wide
      assign freq_shift = {freq_reg[FREQ_W-9:0], i2c.byte_data};
    end else begin : g_freq_byte
      assign freq_shift = i2c.byte_data;
    end
    if (DUTY_W > 8) begin : g_duty_wide
      assign duty_shift = {duty_reg[DUTY_W-9:0], i2c.byte_data};
    end else begin : g_duty_byte
      assign duty_shift = i2c.byte_data;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    after_byte = state_reg;
    ctrl_next  = ctrl_reg;
    freq_next  = freq_reg;
    duty_next  = duty_reg;
    cnt_next   = cnt_reg;
    wait_next  = '0;
    commit     = 1'b0;
    discard    = 1'b0;

    // A byte arriving with STOP is consumed first, so decode it into after_byte
    if (i2c.byte_valid) begin
      case (state_reg)
        CTRL: begin
          if (|i2c.byte_data[7:6]) begin
            after_byte = ABORT;
          end else begin
            ctrl_next = i2c.byte_data[5:0];
            if (i2c.byte_data[C_LF]) begin
              after_byte = FREQ;
              cnt_next   = CNT_W'(FREQ_BYTES);
            end else if (i2c.byte_data[C_LD]) begin
              after_byte = DUTY;
              cnt_next   = CNT_W'(DUTY_BYTES);
            end else begin
              after_byte = WAIT_STOP;
            end
          end
        end
        FREQ: begin
          freq_next = freq_shift;
          cnt_next  = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            if (ctrl_reg[C_LD]) begin
              after_byte = DUTY;
              cnt_next   = CNT_W'(DUTY_BYTES);
            end else begin
              after_byte = WAIT_STOP;
            end
          end
        end
        DUTY: begin
          duty_next = duty_shift;
          cnt_next  = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) after_byte = WAIT_STOP;
        end
        WAIT_STOP: after_byte = ABORT;
        default: ;
      endcase
    end

    case (state_reg)
      IDLE: begin
        if (i2c.frame_start) state_next = CTRL;
      end
      PEND: begin
        // A new START flushes the pending config so it is never lost
        if (i2c.frame_start) begin
          commit     = 1'b1;
          state_next = CTRL;
        end else if (phase_wrap || wait_reg == WAIT_W'(WRAP_TIMEOUT - 1)) begin
          commit     = 1'b1;
          state_next = IDLE;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
      default: begin
        if (i2c.frame_start) begin
          discard    = 1'b1;
          state_next = CTRL;
        end else if (i2c.frame_stop) begin
          if (after_byte == WAIT_STOP) begin
            if (ctrl_next[C_SYNC]) begin
              state_next = PEND;
            end else begin
              commit     = 1'b1;
              state_next = IDLE;
            end
          end else begin
            discard    = 1'b1;
            state_next = IDLE;
          end
        end else begin
          state_next = after_byte;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      ctrl_reg   <= '0;
      freq_reg   <= '0;
      duty_reg   <= '0;
      cnt_reg    <= '0;
      wait_reg   <= '0;
      enable     <= 1'b0;
      wave       <= 2'd0;
      frequency  <= '0;
      duty_cycle <= RESET_DUTY;
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      state_reg  <= state_next;
      ctrl_reg   <= ctrl_next;
      freq_reg   <= freq_next;
      duty_reg   <= duty_next;
      cnt_reg    <= cnt_next;
      wait_reg   <= wait_next;
      cfg_update <= commit;
      frame_err  <= discard;
      // Words not loaded by this frame keep their previous live value
      if (commit) begin
        enable <= ctrl_next[C_EN];
        wave   <= ctrl_next[2:1];
        if (ctrl_next[C_LF]) frequency  <= freq_next;
        if (ctrl_next[C_LD]) duty_cycle <= duty_next;
      end
      if (discard && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_nco_config_ctrl.sv
// Scoreboard bench for nco_config_ctrl: stimulus predicts each commit/discard pulse
// from whole-frame rules; a negedge monitor pops and compares every pulse.
module tb_nco_config_ctrl;
  localparam int FREQ_W = 64;
  localparam int DUTY_W = 16;
  localparam int WRAP_T = 40;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit          is_err;
    int          at_cyc;
    logic        en;
    logic [1:0]  wave;
    logic [63:0] freq;
    logic [15:0] duty;
    logic [7:0]  errs;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic phase_wrap = 1'b0;
  logic enable, cfg_update, busy, frame_err;
  logic [1:0] wave;
  logic [FREQ_W-1:0] frequency;
  logic [DUTY_W-1:0] duty_cycle;
  logic [7:0] err_count;

  nco_config_ctrl_if i2c_bus();

  nco_config_ctrl #(
    .FREQ_W(FREQ_W), .DUTY_W(DUTY_W), .RESET_DUTY(16'h8000), .WRAP_TIMEOUT(WRAP_T)
  ) dut (
    .clk(clk), .reset(reset), .i2c(i2c_bus), .phase_wrap(phase_wrap),
    .enable(enable), .wave(wave), .frequency(frequency), .duty_cycle(duty_cycle),
    .cfg_update(cfg_update), .busy(busy), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  // Reference model of the live outputs (stimulus side) and the monitor's view
  logic        m_en = 0;
  logic [1:0]  m_wave = 0;
  logic [63:0] m_freq = 0;
  logic [15:0] m_duty = 16'h8000;
  logic [7:0]  m_errs = 0;
  logic        cur_en = 0;
  logic [1:0]  cur_wave = 0;
  logic [63:0] cur_freq = 0;
  logic [15:0] cur_duty = 16'h8000;
  logic [7:0]  cur_errs = 0;
  bit          frame_open = 0;

  // Monitor
  exp_t       mon_e;
  logic [93:0] mon_act, mon_exp;
  always @(negedge clk) begin
    if (reset) begin
      if (cfg_update || frame_err) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pulse cyc=%0d cfg_update=%b frame_err=%b required none", cyc, cfg_update, frame_err);
        end else begin
          mon_e   = sb.pop_front();
          mon_act = {cfg_update, frame_err, enable, wave, frequency, duty_cycle, err_count, busy};
          mon_exp = {!mon_e.is_err, mon_e.is_err, mon_e.en, mon_e.wave, mon_e.freq, mon_e.duty, mon_e.errs, mon_e.busy};
          if (mon_act !== mon_exp || cyc != mon_e.at_cyc) begin
            miscompares++;
            $display("FAIL pulse cyc=%0d got %h required %h at cyc %0d", cyc, mon_act, mon_exp, mon_e.at_cyc);
          end else begin
            $display("cyc %0d %s en=%b wave=%0d freq=%h duty=%h errs=%0d", cyc,
                     mon_e.is_err ? "discard" : "commit ", enable, wave, frequency, duty_cycle, err_count);
          end
          cur_en = mon_e.en; cur_wave = mon_e.wave; cur_freq = mon_e.freq;
          cur_duty = mon_e.duty; cur_errs = mon_e.errs;
        end
      end else if ({enable, wave, frequency, duty_cycle, err_count} !==
                   {cur_en, cur_wave, cur_freq, cur_duty, cur_errs}) begin
        vectors++;
        miscompares++;
        $display("FAIL hold cyc=%0d got %h %0d %h %h %0d required %h %0d %h %h %0d", cyc,
                 enable, wave, frequency, duty_cycle, err_count,
                 cur_en, cur_wave, cur_freq, cur_duty, cur_errs);
        cur_en = enable; cur_wave = wave; cur_freq = frequency;
        cur_duty = duty_cycle; cur_errs = err_count;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bq_t mk(input int n, input logic [95:0] v);
    bq_t q;
    for (int i = n - 1; i >= 0; i--) q.push_back(v[8*i +: 8]);
    return q;
  endfunction

  function automatic bit frame_ok(input bq_t b);
    int need;
    if (b.size() == 0) return 0;
    if (b[0][7:6] != 2'b00) return 0;
    need = 1 + (b[0][3] ? FREQ_W / 8 : 0) + (b[0][4] ? DUTY_W / 8 : 0);
    return b.size() == need;
  endfunction

  task automatic push_exp(input bit is_err, input int at, input bit busy_after);
    exp_t e;
    if (is_err && m_errs != 8'd255) m_errs = m_errs + 8'd1;
    e.is_err = is_err; e.at_cyc = at; e.en = m_en; e.wave = m_wave;
    e.freq = m_freq; e.duty = m_duty; e.errs = m_errs; e.busy = busy_after;
    sb.push_back(e);
  endtask

  task automatic apply_commit(input bq_t b);
    int k = 1;
    m_en   = b[0][0];
    m_wave = b[0][2:1];
    if (b[0][3]) begin
      for (int i = 0; i < FREQ_W / 8; i++) begin m_freq = {m_freq[55:0], b[k]}; k++; end
    end
    if (b[0][4]) begin
      for (int i = 0; i < DUTY_W / 8; i++) begin m_duty = {m_duty[7:0], b[k]}; k++; end
    end
  endtask

  // Predict the outcome of a frame ended by STOP driven in cycle s
  task automatic expect_end(input bq_t b, input int s, input int pend_mode, input int d);
    if (!frame_ok(b)) begin
      push_exp(1, s + 1, 0);
    end else begin
      apply_commit(b);
      if (!b[0][5])            push_exp(0, s + 1, 0);
      else if (pend_mode == 0) push_exp(0, s + d + 1, 0);
      else if (pend_mode == 1) push_exp(0, s + 1 + WRAP_T, 0);
      else                     push_exp(0, s + d + 1, 1);
    end
  endtask

  // term: 0 = STOP, 1 = repeated START; pend_mode: 0 wrap after d, 1 timeout, 2 START after d
  task automatic run_frame(input bq_t b, input int term, input bit merge_in, input int pend_mode, input int d);
    bit merge;
    int s = 0;
    merge = merge_in && term == 0 && b.size() > 0;
    if (!frame_open) begin
      i2c_bus.frame_start = 1; tick(); i2c_bus.frame_start = 0;
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_after_start cyc=%0d got %b required 1", cyc, busy);
      end
    end
    frame_open = 0;
    for (int i = 0; i < b.size(); i++) begin
      i2c_bus.byte_valid = 1; i2c_bus.byte_data = b[i];
      phase_wrap = ($urandom_range(0, 3) == 0);
      if (merge && i == b.size() - 1) begin
        i2c_bus.frame_stop = 1; s = cyc;
        expect_end(b, s, pend_mode, d);
      end
      tick();
      i2c_bus.byte_valid = 0; i2c_bus.frame_stop = 0; phase_wrap = 0;
      if (!(merge && i == b.size() - 1)) repeat ($urandom_range(0, 2)) tick();
    end
    if (term == 1) begin
      i2c_bus.frame_start = 1;
      push_exp(1, cyc + 1, 1);
      tick();
      i2c_bus.frame_start = 0;
      frame_open = 1;
      return;
    end
    if (!merge) begin
      i2c_bus.frame_stop = 1; phase_wrap = $urandom_range(0, 1); s = cyc;
      expect_end(b, s, pend_mode, d);
      tick();
      i2c_bus.frame_stop = 0; phase_wrap = 0;
    end
    if (frame_ok(b) && b[0][5]) begin
      if (pend_mode == 0) begin
        repeat (d - 1) tick();
        phase_wrap = 1; tick(); phase_wrap = 0;
      end else if (pend_mode == 1) begin
        repeat (WRAP_T) tick();
      end else begin
        repeat (d - 1) tick();
        i2c_bus.frame_start = 1; phase_wrap = $urandom_range(0, 1);
        tick();
        i2c_bus.frame_start = 0; phase_wrap = 0;
        frame_open = 1;
      end
    end
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    vectors++;
    if ({enable, wave, frequency, duty_cycle, cfg_update, busy, frame_err, err_count} !==
        {1'b0, 2'd0, 64'd0, 16'h8000, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL %s got en=%b wave=%0d freq=%h duty=%h upd=%b busy=%b err=%b cnt=%0d required reset values",
               tag, enable, wave, frequency, duty_cycle, cfg_update, busy, frame_err, err_count);
    end
  endtask

  initial begin
    bq_t fb;
    logic [7:0] c;
    int len, term, mode, d, bound;
    i2c_bus.frame_start = 0; i2c_bus.frame_stop = 0;
    i2c_bus.byte_valid = 0;  i2c_bus.byte_data = 0;
    tick(); tick();
    check_reset_values("reset_state");
    reset = 1;
    tick();

    run_frame(mk(1, 96'h01), 0, 0, 0, 1);
    run_frame(mk(3, 96'h142A10), 0, 0, 0, 1);
    run_frame(mk(9, 96'h08_001A2333FE895001), 0, 0, 0, 1);
    run_frame(mk(9, 96'h28_0123456789ABCDEF), 0, 0, 0, 20);
    run_frame(mk(9, 96'h28_FEDCBA9876543210), 0, 0, 1, 1);
    run_frame(mk(3, 96'h081122), 0, 0, 0, 1);
    run_frame(mk(1, 96'hC1), 0, 0, 0, 1);
    run_frame(mk(2, 96'h10AB), 1, 0, 0, 1);
    run_frame(mk(3, 96'h101234), 0, 0, 0, 1);
    run_frame(mk(3, 96'h35BEEF), 0, 1, 2, 7);
    run_frame(mk(1, 96'h03), 0, 1, 0, 1);
    run_frame(mk(2, 96'h0155), 0, 0, 0, 1);

    for (int n = 0; n < 60; n++) begin
      c = 8'($urandom);
      if ($urandom_range(0, 7) != 0) c[7:6] = 2'b00;
      len = 1 + (c[3] ? 8 : 0) + (c[4] ? 2 : 0);
      if ($urandom_range(0, 4) == 0) len = len + $urandom_range(0, 3) - 2;
      if (len < 0) len = 0;
      fb = {};
      if (len > 0) fb.push_back(c);
      for (int i = 1; i < len; i++) fb.push_back(8'($urandom));
      term = ($urandom_range(0, 9) == 0) ? 1 : 0;
      mode = ($urandom_range(0, 5) == 0) ? 1 : $urandom_range(0, 1) * 2;
      d = $urandom_range(1, WRAP_T - 2);
      run_frame(fb, term, $urandom_range(0, 2) == 0, mode, d);
    end
    if (frame_open) run_frame(mk(1, 96'h00), 0, 0, 0, 1);

    bound = 0;
    while (sb.size() != 0 && bound < 2 * WRAP_T) begin tick(); bound++; end

    // Reset in the middle of a frame drops everything in flight
    i2c_bus.frame_start = 1; tick(); i2c_bus.frame_start = 0;
    i2c_bus.byte_valid = 1; i2c_bus.byte_data = 8'h18; tick();
    i2c_bus.byte_data = 8'h77; tick();
    i2c_bus.byte_valid = 0;
    reset = 0;
    sb.delete();
    m_en = 0; m_wave = 0; m_freq = 0; m_duty = 16'h8000; m_errs = 0;
    cur_en = 0; cur_wave = 0; cur_freq = 0; cur_duty = 16'h8000; cur_errs = 0;
    frame_open = 0;
    #1;
    check_reset_values("reset_mid_frame");
    tick(); tick();
    reset = 1;
    tick();
    check_reset_values("after_reset_release");
    run_frame(mk(3, 96'h15CAFE), 0, 0, 0, 1);

    // Error counter saturates at 255
    for (int n = 0; n < 258; n++) run_frame(mk(1, 96'h80), 0, 0, 0, 1);
    run_frame(mk(1, 96'h05), 0, 0, 0, 1);

    bound = 0;
    while (sb.size() != 0 && bound < 2 * WRAP_T) begin tick(); bound++; end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d outstanding required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d run did not finish in time", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nco_config_ctrl.md
Name: nco_config_ctrl

Overview:
- Sits between the I2C slave byte interface and the NCO core.
- Decodes a control byte plus optional payload bytes into shadow registers.
- Commits the whole configuration atomically on I2C STOP. Commit is either immediate or aligned to an NCO phase wrap.
- Guarantees the NCO never sees a partially written frequency or duty word.

Parameters:
- FREQ_W, 64, frequency word width (multiple of 8)
- DUTY_W, 16, duty word width (multiple of 8)
- RESET_DUTY, 16'h8000, duty_cycle value after reset (50%)
- WRAP_TIMEOUT, 1024, max cycles a synced commit waits for phase_wrap

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- frame_start  in  1  1-cycle pulse: START/repeated START, slave address matched
- frame_stop  in  1  1-cycle pulse: STOP detected
- byte_valid  in  1  1-cycle pulse: byte_data holds a received payload byte (address byte excluded)
- byte_data  in  8  received byte
- phase_wrap  in  1  1-cycle pulse from NCO on phase accumulator wrap
- enable  out  1  NCO enable
- wave  out  2  waveform select
- frequency  out  FREQ_W  NCO tuning word
- duty_cycle  out  DUTY_W  duty word
- cfg_update  out  1  1-cycle pulse on the cycle committed values first appear
- busy  out  1  high from frame_start until commit or discard
- frame_err  out  1  1-cycle pulse when a frame is discarded
- err_count  out  8  saturating count of discarded frames

Behaviour:
- Reset (reset=0, async):
  - enable=0, wave=0, frequency=0, duty_cycle=RESET_DUTY.
  - cfg_update=0, busy=0, frame_err=0, err_count=0.
  - Shadows and counters cleared; FSM goes to IDLE.
- Control byte fields:
  - bit0 enable
  - bits[2:1] wave
  - bit3 LF: FREQ_W/8 frequency bytes follow, MSB first
  - bit4 LD: DUTY_W/8 duty bytes follow, MSB first
  - bit5 SYNC: commit waits for phase_wrap
  - bits[7:6] reserved; a nonzero value is an error
- Payload byte order: frequency bytes first, then duty bytes.
- Expected byte count = 1 + 8·LF + 2·LD (defaults).
- FSM states: IDLE, CTRL, FREQ, DUTY, WAIT_STOP, PEND, ABORT.
  - IDLE: frame_start -> CTRL, busy=1. Bytes and stop are ignored.
  - CTRL: byte -> latch shadow; next state is FREQ if LF, else DUTY if LD, else WAIT_STOP. Reserved bits set -> ABORT.
  - FREQ/DUTY: each byte shifts into its shadow and a down-counter decrements. At zero -> DUTY (if LD and leaving FREQ) or WAIT_STOP.
  - WAIT_STOP: frame_stop -> commit if SYNC=0, else PEND. Any further byte -> ABORT (overrun).
  - PEND: commit on the cycle after phase_wrap is sampled high, or when the wait counter reaches WRAP_TIMEOUT-1, whichever is first.
  - frame_stop in CTRL/FREQ/DUTY (short frame) -> discard.
  - ABORT: wait for frame_stop, then discard.
- Commit timing and scope:
  - Immediate commit: outputs update, and cfg_update=1, in the clock edge after frame_stop is sampled. Latency is 1 cycle.
  - enable and wave always update on commit.
  - frequency updates only if LF; duty_cycle updates only if LD. Otherwise they hold their values.
- Discard:
  - Live outputs are unchanged.
  - frame_err pulses 1 cycle; err_count increments and saturates at 255.
  - FSM returns to IDLE, busy=0.
- Simultaneous and boundary events:
  - byte_valid and frame_stop in the same cycle: the byte is processed first, then the stop. A frame completed by that byte commits.
  - frame_start while in CTRL/FREQ/DUTY/WAIT_STOP/ABORT (repeated START): the current frame is discarded with frame_err, and a new frame begins in CTRL the same cycle.
  - frame_start while in PEND: the pending config commits immediately (cfg_update) and the new frame begins. The pending config is never lost.
  - phase_wrap and frame_start in the same cycle in PEND: a single commit only.
  - SYNC frame with phase_wrap on the same cycle as frame_stop: that wrap does not count; wait for the next one.
  - Reset asserted mid-frame or in PEND: all pending data is dropped and outputs return to reset values.
- busy:
  - Deasserts in the same cycle cfg_update or frame_err pulses.
  - Remains high in PEND.

Test Plan:
- Reset, then frame [8'h01], stop -> cfg_update 1 cycle after stop; enable=1, wave=0, frequency=0, duty_cycle=16'h8000.
- Frame [8'h14, 8'h2A, 8'h10] (wave=2, LD), stop -> duty_cycle=16'h2A10, wave=2, enable=0, frequency unchanged.
- Frame [8'h08, 8'h00, 8'h1A, 8'h23, 8'h33, 8'hFE, 8'h89, 8'h50, 8'h01], stop -> frequency=64'h001A2333FE895001, single cfg_update.
- Frame [8'h28] + 8 frequency bytes, stop, phase_wrap 20 cycles later -> outputs unchanged until the edge after phase_wrap. Repeat with no wrap -> commit at WRAP_TIMEOUT.
- Frame [8'h08, 8'h11, 8'h22] then stop (short); frame [8'hC1], stop (reserved bits) -> no output change, two frame_err pulses, err_count=2.
- Frame [8'h10, 8'hAB], then frame_start before the 2nd duty byte -> frame_err. Then full frame [8'h10, 8'h12, 8'h34], stop -> duty_cycle=16'h1234. Reset mid-frame -> reset values, busy=0.
